// File: rtl/trace_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module  : trace_collector_pkg
// Brief   : Record layout, marker value and record-kind encoding shared by
//           the trace collector and its FIFO user.
// Revision: 1.0 - initial release
// ============================================================================
package trace_collector_pkg;

    localparam int c_SKIP_W    = 32;
    localparam int c_INSTR_W   = 32;
    localparam int c_SKIP_LSB  = 0;
    localparam int c_INSTR_LSB = c_SKIP_LSB + c_SKIP_W;
    localparam int c_PC_LSB    = c_INSTR_LSB + c_INSTR_W;

    localparam logic [c_INSTR_W-1:0] c_MARKER_INSTR = 32'h0;
    localparam logic [c_SKIP_W-1:0]  c_SKIP_MAX     = '1;
    localparam logic [31:0]          c_LOST_MAX     = '1;

    typedef enum logic [1:0] {
        REC_NONE   = 2'd0,
        REC_KEPT   = 2'd1,
        REC_MARKER = 2'd2
    } rec_kind_e;

    function automatic int rec_width(input int pc_width);
        return pc_width + c_PC_LSB;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module  : trace_fifo
// Brief   : Synchronous FIFO with level output; accepts a push while full
//           when a pop happens in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_ok,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       not_empty
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam int                c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    logic w_do_pop;
    logic w_full;

    assign w_do_pop  = pop && (r_level != '0);
    assign w_full    = (r_level == c_FULL);
    assign push_ok   = push && (!w_full || w_do_pop);
    assign pop_data  = r_mem[r_rd_ptr];
    assign level     = r_level;
    assign not_empty = (r_level != '0);

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push_ok)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push_ok, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/trace_collector.sv
`default_nettype none
// ============================================================================
// Module  : trace_collector
// Brief   : Compresses a retired-instruction stream into {pc, instr, skip}
//           records (kept events and flush markers) buffered in a FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module trace_collector
    import trace_collector_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int PC_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic [PC_WIDTH-1:0]       in_pc,
    input  logic [31:0]               in_instr,
    input  logic                      drop_instr,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_WIDTH+63:0]      out_data,
    output logic                      overflow,
    output logic [31:0]               lost_count,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int c_REC_W = rec_width(PC_WIDTH);

    rec_kind_e            w_kind;
    logic                 w_dropped;
    logic                 w_push;
    logic                 w_push_ok;
    logic                 w_pop;
    logic [c_REC_W-1:0]   w_rec;
    logic [c_SKIP_W-1:0]  w_skip_next;

    logic [c_SKIP_W-1:0]  r_skip_count;
    logic                 r_overflow;
    logic [31:0]          r_lost_count;

    // A kept instruction always wins over a flush in the same cycle.
    always_comb begin
        w_kind = REC_NONE;
        if (en && in_valid && !drop_instr) begin
            w_kind = REC_KEPT;
        end else if (en && flush) begin
            w_kind = REC_MARKER;
        end
    end

    assign w_dropped = en && in_valid && drop_instr;
    assign w_push    = (w_kind != REC_NONE);
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_rec = '0;
        w_rec[c_SKIP_LSB +: c_SKIP_W] = r_skip_count;
        if (w_kind == REC_KEPT) begin
            w_rec[c_INSTR_LSB +: c_INSTR_W] = in_instr;
            w_rec[c_PC_LSB +: PC_WIDTH]     = in_pc;
        end else begin
            w_rec[c_INSTR_LSB +: c_INSTR_W] = c_MARKER_INSTR;
        end
    end

    // A record consumes the count even if the FIFO rejects it; a drop that
    // coincides with a flush starts the next run at one.
    always_comb begin
        w_skip_next = r_skip_count;
        if (w_push) begin
            w_skip_next = w_dropped ? c_SKIP_W'(1) : '0;
        end else if (w_dropped && (r_skip_count != c_SKIP_MAX)) begin
            w_skip_next = r_skip_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skip_count <= '0;
            r_overflow   <= 1'b0;
            r_lost_count <= '0;
        end else begin
            r_skip_count <= w_skip_next;
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
                if (r_lost_count != c_LOST_MAX) begin
                    r_lost_count <= r_lost_count + 1'b1;
                end
            end
        end
    end

    trace_fifo #(
        .WIDTH (c_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_rec),
        .push_ok   (w_push_ok),
        .pop       (w_pop),
        .pop_data  (out_data),
        .level     (fifo_level),
        .not_empty (out_valid)
    );

    assign overflow   = r_overflow;
    assign lost_count = r_lost_count;

endmodule
`default_nettype wire

// File: tb/tb_trace_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_trace_collector
// Brief   : Randomised and directed bench for trace_collector with a
//           queue-based reference model and a decoupled output monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_trace_collector;

    localparam int DEPTH = 16;
    localparam int PW    = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            in_valid;
    logic [PW-1:0]   in_pc;
    logic [31:0]     in_instr;
    logic            drop_instr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PW+63:0]  out_data;
    logic            overflow;
    logic [31:0]     lost_count;
    logic [4:0]      fifo_level;

    trace_collector #(.DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .drop_instr (drop_instr),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overflow   (overflow),
        .lost_count (lost_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [127:0]  exp_q[$];
    int            m_level;
    logic [31:0]   m_skip;
    logic [31:0]   m_lost;
    bit            m_ovf;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every handshake must deliver the oldest expected record.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_data: got %h expected no record", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; the model decides acceptance from its own
    // occupancy and the consumer's readiness.
    task automatic step(input bit e, input bit v, input logic [63:0] pc,
                        input logic [31:0] ins, input bit d, input bit f, input bit r);
        bit kept, dropped, mark, pop, push, acc;
        logic [127:0] rec;
        en = e; in_valid = v; in_pc = pc; in_instr = ins;
        drop_instr = d; flush = f; out_ready = r;
        kept    = e && v && !d;
        dropped = e && v && d;
        mark    = e && f && !kept;
        push    = kept || mark;
        pop     = r && (m_level > 0);
        rec     = kept ? {pc, ins, m_skip} : {64'h0, 32'h0, m_skip};
        acc     = push && ((m_level < DEPTH) || pop);
        @(posedge clk); #1;
        if (acc) exp_q.push_back(rec);
        m_level = m_level + int'(acc) - int'(pop);
        if (push && !acc) begin
            m_ovf = 1'b1;
            if (m_lost != 32'hFFFF_FFFF) m_lost = m_lost + 1;
        end
        if (push)                                m_skip = dropped ? 32'd1 : 32'd0;
        else if (dropped && m_skip != '1)        m_skip = m_skip + 1;
        chk("fifo_level", 128'(fifo_level), 128'(m_level));
        chk("out_valid",  128'(out_valid),  128'(m_level != 0));
        chk("overflow",   128'(overflow),   128'(m_ovf));
        chk("lost_count", 128'(lost_count), 128'(m_lost));
    endtask

    task automatic idle(input bit r);
        step(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && m_level != 0; i++) idle(1'b1);
        idle(1'b1);
        chk("drain_valid", 128'(out_valid), 128'(0));
        chk("drain_scoreboard", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1; #1;
        chk("rst_valid",    128'(out_valid),  128'(0));
        chk("rst_level",    128'(fifo_level), 128'(0));
        chk("rst_overflow", 128'(overflow),   128'(0));
        chk("rst_lost",     128'(lost_count), 128'(0));
        exp_q.delete();
        m_level = 0; m_skip = '0; m_lost = '0; m_ovf = 1'b0;
        en = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        drop_instr = 1'b0; flush = 1'b0; out_ready = 1'b0;
        m_level = 0; m_skip = '0; m_lost = '0; m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid",    128'(out_valid),  128'(0));
        chk("reset_level",    128'(fifo_level), 128'(0));
        chk("reset_overflow", 128'(overflow),   128'(0));
        chk("reset_lost",     128'(lost_count), 128'(0));
        rst = 1'b0;

        // Three drops then a kept jump.
        repeat (3) step(1'b1, 1'b1, 64'h44, 32'h13, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'h1000, 32'h0000_006F, 1'b0, 1'b0, 1'b0);
        chk("dir_first_rec", out_data, {64'h1000, 32'h6F, 32'd3});
        drain();

        // Backpressure into overflow, then full-with-pop.
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, 64'h2000 + 64'(4 * i), 32'h0000_0063 + 32'(i), 1'b0, 1'b0, 1'b0);
        chk("bp_level", 128'(fifo_level), 128'(16));
        chk("bp_ovf",   128'(overflow),   128'(1));
        chk("bp_lost",  128'(lost_count), 128'(4));
        step(1'b1, 1'b1, 64'h3000, 32'h0000_0067, 1'b0, 1'b0, 1'b1);
        chk("fullpop_level", 128'(fifo_level), 128'(16));
        chk("fullpop_lost",  128'(lost_count), 128'(4));
        drain();

        // Flush marker after five drops, then flush together with a keep.
        repeat (5) step(1'b1, 1'b1, 64'h50, 32'h33, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("flush_marker", out_data, {64'h0, 32'h0, 32'd5});
        step(1'b1, 1'b1, 64'h55, 32'h1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 64'h6000, 32'h0000_8067, 1'b0, 1'b1, 1'b1);
        drain();

        // Enable gating keeps the pending skip count untouched.
        repeat (2) step(1'b1, 1'b1, 64'h70, 32'h13, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 64'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'b1);
        chk("gate_level", 128'(fifo_level), 128'(0));
        step(1'b1, 1'b1, 64'h7000, 32'h0000_00EF, 1'b0, 1'b0, 1'b1);
        drain();

        // Reset mid-stream with six buffered records and a pending count.
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 64'h8000 + 64'(i), 32'h6F, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'h90, 32'h13, 1'b1, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 1'b1, 64'h9000, 32'h0000_006F, 1'b0, 1'b0, 1'b1);
        drain();

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 9) != 0), 1'($urandom), {$urandom, $urandom}, $urandom,
                 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
